// File: rtl/ibm_sms_timing_ring_if.sv
// Console-side bundle for the SMS timing-ring card: start/stop/step
// requests toward the card and the timing ring, status and cycle
// counter back to the console.
interface ibm_sms_timing_ring_if #(
   parameter int PHASES = 10,
   parameter int CW     = 16
);
   localparam int PW = $clog2(PHASES);

   logic              start;
   logic              stop;
   logic              step_mode;
   logic [PHASES-1:0] t;
   logic [PW-1:0]     phase;
   logic              running;
   logic              cycle_end;
   logic [CW-1:0]     cycle_count;

   modport master (
      output start, stop, step_mode,
      input  t, phase, running, cycle_end, cycle_count
   );

   modport slave (
      input  start, stop, step_mode,
      output t, phase, running, cycle_end, cycle_count
   );
endinterface

// File: rtl/ibm_sms_timing_ring.sv
// SMS timing-ring card: divides the master clock into a one-hot ring of
// PHASES timing pulses, each DIVIDE clocks wide, under start/stop control
// that always lets the current memory cycle finish before halting.
// Optional feature macro: TAF_SINGLE_STEP_EN (honours step_mode; when
// undefined step_mode is accepted but has no effect).
module ibm_sms_timing_ring #(
   parameter int PHASES = 10,
   parameter int DIVIDE = 4,
   parameter int CW     = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   ibm_sms_timing_ring_if.slave bus
);
   localparam int PW = $clog2(PHASES);
   localparam int DW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
   localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
   localparam logic [DW-1:0] LAST_DIV   = DW'(DIVIDE - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOPPING
   } stateType;

   stateType          state;
   stateType          stateNext;
   logic [DW-1:0]     divCount;
   logic [DW-1:0]     divNext;
   logic [PW-1:0]     phaseReg;
   logic [PW-1:0]     phaseNext;
   logic [PHASES-1:0] tReg;
   logic [PHASES-1:0] tNext;
   logic              runningReg;
   logic              cycleEndReg;
   logic              cycleEndNext;
   logic [CW-1:0]     cycleCount;
   logic              stepReq;
   logic              haltReq;
   logic              lastClock;

   // A single-step request behaves exactly like a stop request; without the
   // feature the port is tied off so it cannot influence the ring.
`ifdef TAF_SINGLE_STEP_EN
   assign stepReq = bus.step_mode;
`else
   logic unusedStepMode;
   assign unusedStepMode = bus.step_mode;
   assign stepReq        = 1'b0;
`endif

   assign haltReq   = bus.stop || stepReq;
   assign lastClock = (divCount == LAST_DIV) && (phaseReg == LAST_PHASE);

   // Next-state logic: the STOPPING state itself is the stop latch, so a
   // one-clock stop pulse is remembered until the cycle boundary, where the
   // ring drops to IDLE instead of wrapping to phase 0.
   always_comb begin
      stateNext = state;
      divNext   = divCount;
      phaseNext = phaseReg;
      unique case (state)
         IDLE: begin
            divNext   = '0;
            phaseNext = '0;
            if (bus.start) begin
               stateNext = haltReq ? STOPPING : RUN;
            end
         end
         RUN, STOPPING: begin
            if (divCount == LAST_DIV) begin
               divNext   = '0;
               phaseNext = (phaseReg == LAST_PHASE) ? '0 : phaseReg + PW'(1);
            end else begin
               divNext = divCount + DW'(1);
            end
            if (lastClock) begin
               stateNext = ((state == STOPPING) || haltReq) ? IDLE : RUN;
            end else if (haltReq) begin
               stateNext = STOPPING;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      tNext        = (stateNext == IDLE) ? '0 : (PHASES'(1) << phaseNext);
      cycleEndNext = (stateNext != IDLE) && (phaseNext == LAST_PHASE) &&
                     (divNext == LAST_DIV);
   end

   // FSM state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Registered divider, phase index and timing outputs so every output
   // changes only on the clock edge and t is built directly as one-hot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         divCount    <= '0;
         phaseReg    <= '0;
         tReg        <= '0;
         runningReg  <= 1'b0;
         cycleEndReg <= 1'b0;
      end else begin
         divCount    <= divNext;
         phaseReg    <= phaseNext;
         tReg        <= tNext;
         runningReg  <= (stateNext != IDLE);
         cycleEndReg <= cycleEndNext;
      end
   end

   // Completed-cycle counter advances on the edge that ends a cycle_end clock.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycleCount <= '0;
      end else if (cycleEndReg) begin
         cycleCount <= cycleCount + CW'(1);
      end
   end

   assign bus.t           = tReg;
   assign bus.phase       = phaseReg;
   assign bus.running     = runningReg;
   assign bus.cycle_end   = cycleEndReg;
   assign bus.cycle_count = cycleCount;
endmodule

// File: tb/tb_ibm_sms_timing_ring.sv
// Directed bench for the SMS timing ring: a PHASES=10/DIVIDE=4 card for
// run, stop, start+stop, single-step and reset scenarios, plus a
// PHASES=2/DIVIDE=1/CW=2 card for the boundary case.
`timescale 1ns/1ps
module tb_ibm_sms_timing_ring;
   localparam int PA  = 10;
   localparam int DA  = 4;
   localparam int CA  = 16;
   localparam int PB  = 2;
   localparam int DB  = 1;
   localparam int CB  = 2;
   localparam int PWA = $clog2(PA);
   localparam int CYC = PA * DA;

   logic clk = 1'b0;
   logic rstnA;
   logic rstnB;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ibm_sms_timing_ring_if #(.PHASES(PA), .CW(CA)) busA ();
   ibm_sms_timing_ring_if #(.PHASES(PB), .CW(CB)) busB ();

   ibm_sms_timing_ring #(.PHASES(PA), .DIVIDE(DA), .CW(CA)) dutA (
      .clk   (clk),
      .rst_n (rstnA),
      .bus   (busA)
   );

   ibm_sms_timing_ring #(.PHASES(PB), .DIVIDE(DB), .CW(CB)) dutB (
      .clk   (clk),
      .rst_n (rstnB),
      .bus   (busB)
   );

   // Drives the console inputs of the main card.
   task automatic applyStimulus(input logic s, input logic p, input logic m);
      busA.start     = s;
      busA.stop      = p;
      busA.step_mode = m;
   endtask

   // Drives the console inputs of the boundary card.
   task automatic applyStimulusB(input logic s, input logic p, input logic m);
      busB.start     = s;
      busB.stop      = p;
      busB.step_mode = m;
   endtask

   // Holds the main card in reset for two edges, then releases it.
   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0);
      rstnA = 1'b0;
      repeat (2) @(negedge clk);
      rstnA = 1'b1;
   endtask

   // Resets both cards and checks every output of the main card.
   task automatic test_reset();
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulusB(1'b0, 1'b0, 1'b0);
      rstnA = 1'b0;
      rstnB = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busA.t !== '0) begin
         failures++;
         $display("[TB] FAIL reset_t got %b want 0", busA.t);
      end
      checks++;
      if (busA.phase !== '0) begin
         failures++;
         $display("[TB] FAIL reset_phase got %0d want 0", busA.phase);
      end
      checks++;
      if (busA.running !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_running got %b want 0", busA.running);
      end
      checks++;
      if (busA.cycle_end !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_cycle_end got %b want 0", busA.cycle_end);
      end
      checks++;
      if (busA.cycle_count !== '0) begin
         failures++;
         $display("[TB] FAIL reset_count got %0d want 0", busA.cycle_count);
      end
      rstnA = 1'b1;
      rstnB = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busA.running !== 1'b0 || busA.t !== '0) begin
         failures++;
         $display("[TB] FAIL idle_hold got running=%b t=%b want 0/0", busA.running, busA.t);
      end
   endtask

   // Starts with a one-clock start pulse and follows three full cycles.
   task automatic test_run();
      logic [PA-1:0]  expT;
      logic [PWA-1:0] expPh;
      logic           expEnd;
      logic [CA-1:0]  expCnt;
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 3 * CYC + 1; c++) begin
         expPh  = PWA'(((c - 1) / DA) % PA);
         expT   = PA'(1) << expPh;
         expEnd = ((c % CYC) == 0);
         expCnt = CA'((c - 1) / CYC);
         checks++;
         if (busA.t !== expT || busA.phase !== expPh || busA.cycle_end !== expEnd ||
             busA.running !== 1'b1 || busA.cycle_count !== expCnt) begin
            failures++;
            $display("[TB] FAIL run c=%0d got t=%b ph=%0d end=%b run=%b cnt=%0d want t=%b ph=%0d end=%b run=1 cnt=%0d",
                     c, busA.t, busA.phase, busA.cycle_end, busA.running, busA.cycle_count,
                     expT, expPh, expEnd, expCnt);
         end
         @(negedge clk);
      end
   endtask

   // One-clock stop pulse in phase 3 of cycle 2; cycle 2 must still finish.
   task automatic test_stop_mid_cycle();
      logic [PA-1:0]  expT;
      logic [PWA-1:0] expPh;
      logic           expEnd;
      logic           expRun;
      logic [CA-1:0]  expCnt;
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 83; c++) begin
         if (c <= 2 * CYC) begin
            expPh  = PWA'(((c - 1) / DA) % PA);
            expT   = PA'(1) << expPh;
            expEnd = ((c % CYC) == 0);
            expRun = 1'b1;
            expCnt = CA'((c - 1) / CYC);
         end else begin
            expPh  = '0;
            expT   = '0;
            expEnd = 1'b0;
            expRun = 1'b0;
            expCnt = CA'(2);
         end
         checks++;
         if (busA.t !== expT || busA.phase !== expPh || busA.cycle_end !== expEnd ||
             busA.running !== expRun || busA.cycle_count !== expCnt) begin
            failures++;
            $display("[TB] FAIL stop c=%0d got t=%b ph=%0d end=%b run=%b cnt=%0d want t=%b ph=%0d end=%b run=%b cnt=%0d",
                     c, busA.t, busA.phase, busA.cycle_end, busA.running, busA.cycle_count,
                     expT, expPh, expEnd, expRun, expCnt);
         end
         applyStimulus(1'b0, (c == 53), 1'b0);
         @(negedge clk);
      end
   endtask

   // Start and stop together from IDLE: exactly one cycle, then IDLE.
   task automatic test_start_stop_idle();
      int active = 0;
      int ends   = 0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= CYC + 5; c++) begin
         if (busA.running === 1'b1) active++;
         if (busA.cycle_end === 1'b1) ends++;
         @(negedge clk);
      end
      checks++;
      if (active != CYC) begin
         failures++;
         $display("[TB] FAIL startstop_active got %0d want %0d", active, CYC);
      end
      checks++;
      if (ends != 1) begin
         failures++;
         $display("[TB] FAIL startstop_ends got %0d want 1", ends);
      end
      checks++;
      if (busA.cycle_count !== CA'(3) || busA.t !== '0) begin
         failures++;
         $display("[TB] FAIL startstop_final got cnt=%0d t=%b want 3/0", busA.cycle_count, busA.t);
      end
   endtask

   // step_mode with start held: one-idle-clock gaps only when the feature is built in.
   task automatic test_single_step();
      logic expRun;
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      for (int c = 1; c <= 100; c++) begin
`ifdef TAF_SINGLE_STEP_EN
         expRun = !(c == CYC + 1 || c == 2 * CYC + 2);
`else
         expRun = 1'b1;
`endif
         checks++;
         if (busA.running !== expRun) begin
            failures++;
            $display("[TB] FAIL step c=%0d got running=%b want %b", c, busA.running, expRun);
         end
         if (c == 100) applyStimulus(1'b0, 1'b0, 1'b0);
         @(negedge clk);
      end
   endtask

   // Reset during phase 6 of cycle 2 clears everything and stays idle.
   task automatic test_reset_mid_run();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (64) @(negedge clk);
      checks++;
      if (busA.phase !== PWA'(6) || busA.cycle_count !== CA'(1)) begin
         failures++;
         $display("[TB] FAIL midrun_pre got ph=%0d cnt=%0d want 6/1", busA.phase, busA.cycle_count);
      end
      rstnA = 1'b0;
      @(negedge clk);
      checks++;
      if (busA.t !== '0 || busA.phase !== '0 || busA.running !== 1'b0 ||
          busA.cycle_end !== 1'b0 || busA.cycle_count !== '0) begin
         failures++;
         $display("[TB] FAIL midrun_reset got t=%b ph=%0d run=%b end=%b cnt=%0d want all 0",
                  busA.t, busA.phase, busA.running, busA.cycle_end, busA.cycle_count);
      end
      rstnA = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (busA.running !== 1'b0 || busA.t !== '0) begin
         failures++;
         $display("[TB] FAIL midrun_norestart got run=%b t=%b want 0/0", busA.running, busA.t);
      end
   endtask

   // PHASES=2, DIVIDE=1, CW=2: alternating pulses and counter wrap.
   task automatic test_boundary();
      logic [PB-1:0] expT;
      logic          expPh;
      logic          expEnd;
      logic [CB-1:0] expCnt;
      applyStimulusB(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulusB(1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         expT   = (c % 2 == 1) ? 2'b01 : 2'b10;
         expPh  = (c % 2 == 0);
         expEnd = (c % 2 == 0);
         expCnt = CB'(((c - 1) / 2) % 4);
         checks++;
         if (busB.t !== expT || busB.phase !== expPh || busB.cycle_end !== expEnd ||
             busB.cycle_count !== expCnt || !$onehot(busB.t)) begin
            failures++;
            $display("[TB] FAIL boundary c=%0d got t=%b ph=%b end=%b cnt=%0d want t=%b ph=%b end=%b cnt=%0d",
                     c, busB.t, busB.phase, busB.cycle_end, busB.cycle_count,
                     expT, expPh, expEnd, expCnt);
         end
         @(negedge clk);
      end
   endtask

   // Scenario sequence and final summary.
   initial begin
      rstnA = 1'b0;
      rstnB = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulusB(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      test_reset();
      test_run();
      test_stop_mid_cycle();
      test_start_stop_idle();
      test_single_step();
      test_reset_mid_run();
      test_boundary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
